fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller for the 10-bit core's program ROM (combinational-read, 10-bit address/data).
//  Owns the program counter, drives the ROM address, registers each fetched word and presents it to decode
//  with a valid/ready handshake. Takes branch/jump redirects from execute and stops fetching on the HALT word.
//  Sits between the program ROM and the decode stage; one instance per core.
// PARAMETERS
//  AW          10            ROM address width; PC width
//  IW          10            instruction width
//  START_ADDR  10'd1         PC loaded on reset and on start
//  HALT_WORD   10'b0010000010  encoding of halt; fetch stops after it is delivered
//  CW          16            width of instr_count
// PORTS
//  clk           in   1    clock; all state changes on rising edge
//  rst_n         in   1    reset, synchronous, active-low
//  start         in   1    begin fetching at START_ADDR (honoured in IDLE and HALT only)
//  rom_addr      out  AW   ROM address; always equals pc
//  rom_data      in   IW   ROM read data, valid same cycle as rom_addr
//  instr         out  IW   registered instruction to decode
//  instr_valid   out  1    instr holds an undelivered word
//  instr_ready   in   1    decode accepts instr this cycle when instr_valid=1
//  redirect      in   1    taken branch/jump from execute; flush and refetch
//  redirect_addr in   AW   new PC for redirect
//  pc            out  AW   address of next word to fetch
//  halted        out  1    1 while in HALT
//  instr_count   out  CW   number of accepted handshakes since start; saturates at all-ones
// BEHAVIOUR
//  Clock is clk; reset is synchronous, active-low (rst_n). Sampled only at the rising edge of clk.
//  Reset (rst_n=0 at edge): state=IDLE, pc=START_ADDR, instr=0, instr_valid=0, halted=0, instr_count=0.
//   Reset overrides start/redirect/handshake in the same cycle, including reset mid-run.
//  States: IDLE, RUN, DRAIN, HALT. Priority per edge: reset > redirect > load/accept.
//  IDLE: no fetch, instr_valid=0. start=1 -> pc<=START_ADDR, instr_count<=0, RUN.
//  RUN: load = !instr_valid || instr_ready.
//   load & !redirect: instr<=rom_data, instr_valid<=1, pc<=pc+1 (mod 2^AW, 1023->0);
//    if rom_data==HALT_WORD -> DRAIN (pc still increments).
//   !load: instr, instr_valid and pc held stable (no change while valid & !ready).
//   Throughput: 1 word/cycle with instr_ready=1; first valid 1 edge after RUN entry.
//  Accept = instr_valid & instr_ready; each accept increments instr_count (saturating).
//  redirect=1 in RUN or DRAIN: instr_valid<=0, pc<=redirect_addr, state<=RUN, no load that edge.
//   If accept coincides with redirect, the word counts as accepted (instr_count increments).
//   redirect in IDLE or HALT ignored; redirect_addr not range-checked.
//  DRAIN: halt word held in instr, no further fetch; accept -> instr_valid<=0, halted<=1, HALT.
//  HALT: instr_valid=0, halted=1, pc frozen. start=1 -> pc<=START_ADDR, halted<=0, instr_count<=0, RUN.
//  start in RUN/DRAIN ignored. rom_addr = pc combinationally; all other outputs registered.
// TESTING
//  1 Reset, start pulse, instr_ready=1, no redirect, halt at addr 11 -> words addr 1..11 delivered one per
//    cycle, first valid 1 edge after start; then halted=1, instr_valid=0, instr_count=11, pc=12.
//  2 Hold instr_ready=0 for 3 cycles while instr=mem[4] -> instr, instr_valid=1, pc=5 stable; resumes with mem[5].
//  3 redirect=1, redirect_addr=4 while instr=mem[10] valid, ready=1 -> next cycle instr_valid=0, rom_addr=4;
//    following edge instr=mem[4]; instr_count includes mem[10].
//  4 Halt word in DRAIN with instr_ready=0, then redirect to 4 -> halted stays 0, state RUN, mem[4] fetched.
//  5 redirect_addr=1023 -> after fetching mem[1023], pc=0 and rom_addr=0 (wrap).
//  6 rst_n=0 mid-run with start=1 and redirect=1 -> next edge instr_valid=0, pc=1, instr_count=0, IDLE;
//    in HALT, start -> RUN, count cleared, refetches from addr 1.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational ROM
// and hands registered words to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter int             AW         = 10,
    parameter int             IW         = 10,
    parameter logic [AW-1:0]  START_ADDR = 10'd1,
    parameter logic [IW-1:0]  HALT_WORD  = 10'b0010000010,
    parameter int             CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [IW-1:0] rom_data,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic [CW-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [IW-1:0] instr_q;
    logic          valid_q;
    logic          halted_q;
    logic [CW-1:0] count_q;

    logic          load;
    logic          accept;

    assign load        = !valid_q || instr_ready;
    assign accept      = valid_q && instr_ready;

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

    // Fetch FSM: PC, output word register, halt flag and handshake counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= START_ADDR;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // A word taken by decode always counts, even under a redirect.
            if (accept && (count_q != {CW{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pc_q    <= START_ADDR;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= redirect_addr;
                    end else if (load) begin
                        instr_q <= rom_data;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + 1'b1;
                        if (rom_data == HALT_WORD) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= redirect_addr;
                        state_q <= RUN;
                    end else if (accept) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end
                end
                HALT: begin
                    if (start) begin
                        pc_q     <= START_ADDR;
                        halted_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural program ROM.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [9:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [9:0]  redirect_addr;
    logic [9:0]  pc;
    logic        halted;
    logic [15:0] instr_count;

    logic [9:0]  mem [1024];
    logic [9:0]  halt_w;

    int pass_cnt = 0;
    int total    = 0;

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .pc           (pc),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    assign rom_data = mem[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        halt_w = 10'b0010000010;
        for (int a = 0; a < 1024; a++) begin
            mem[a] = 10'(a) | 10'h200;
        end
        mem[11] = halt_w;

        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b1;
        redirect = 1'b0; redirect_addr = '0;
        step();
        step();
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_pc", 32'(pc), 1);
        chk("rst_addr", 32'(rom_addr), 1);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_count", 32'(instr_count), 0);
        chk("rst_instr", 32'(instr), 0);

        // Run 1..11 with ready held high
        rst_n = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_entry_valid", 32'(instr_valid), 0);
        chk("t1_entry_pc", 32'(pc), 1);
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("t1_instr", 32'(instr), 32'(mem[k]));
            chk("t1_valid", 32'(instr_valid), 1);
            chk("t1_pc", 32'(pc), 32'(k + 1));
        end
        step();
        chk("t1_halted", 32'(halted), 1);
        chk("t1_valid_off", 32'(instr_valid), 0);
        chk("t1_count", 32'(instr_count), 11);
        chk("t1_pc_end", 32'(pc), 12);
        step();
        chk("t1_pc_frozen", 32'(pc), 12);

        // Restart from HALT, then stall on mem[4]
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_count_clr", 32'(instr_count), 0);
        chk("t2_halted_clr", 32'(halted), 0);
        chk("t2_pc", 32'(pc), 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t2_instr", 32'(instr), 32'(mem[k]));
        end
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_hold_instr", 32'(instr), 32'(mem[4]));
            chk("t2_hold_valid", 32'(instr_valid), 1);
            chk("t2_hold_pc", 32'(pc), 5);
        end
        chk("t2_hold_count", 32'(instr_count), 3);
        instr_ready = 1'b1;
        step();
        chk("t2_resume", 32'(instr), 32'(mem[5]));
        chk("t2_resume_cnt", 32'(instr_count), 4);
        for (int k = 6; k <= 10; k++) begin
            step();
        end
        chk("t3_pre_instr", 32'(instr), 32'(mem[10]));

        // Redirect while mem[10] is being accepted
        redirect = 1'b1; redirect_addr = 10'd4;
        step();
        redirect = 1'b0;
        chk("t3_valid", 32'(instr_valid), 0);
        chk("t3_addr", 32'(rom_addr), 4);
        chk("t3_count", 32'(instr_count), 10);
        step();
        chk("t3_instr", 32'(instr), 32'(mem[4]));
        chk("t3_valid2", 32'(instr_valid), 1);
        chk("t3_count2", 32'(instr_count), 10);

        // Reach halt word, stall in DRAIN, then redirect out
        for (int k = 5; k <= 11; k++) begin
            step();
        end
        chk("t4_halt_word", 32'(instr), 32'(halt_w));
        chk("t4_count", 32'(instr_count), 17);
        instr_ready = 1'b0;
        step();
        chk("t4_drain_valid", 32'(instr_valid), 1);
        chk("t4_drain_halted", 32'(halted), 0);
        chk("t4_drain_pc", 32'(pc), 12);
        redirect = 1'b1; redirect_addr = 10'd4;
        step();
        redirect = 1'b0; instr_ready = 1'b1;
        chk("t4_redir_valid", 32'(instr_valid), 0);
        chk("t4_redir_pc", 32'(pc), 4);
        chk("t4_redir_halted", 32'(halted), 0);
        step();
        chk("t4_fetch", 32'(instr), 32'(mem[4]));
        chk("t4_fetch_valid", 32'(instr_valid), 1);
        chk("t4_halted2", 32'(halted), 0);

        // Wrap from 1023 to 0
        redirect = 1'b1; redirect_addr = 10'd1023;
        step();
        redirect = 1'b0;
        chk("t5_pc", 32'(pc), 1023);
        chk("t5_count", 32'(instr_count), 18);
        step();
        chk("t5_instr", 32'(instr), 32'(mem[1023]));
        chk("t5_pc_wrap", 32'(pc), 0);
        chk("t5_addr_wrap", 32'(rom_addr), 0);
        step();
        chk("t5_instr0", 32'(instr), 32'(mem[0]));
        chk("t5_pc1", 32'(pc), 1);

        // Reset mid-run beats start and redirect
        rst_n = 1'b0; start = 1'b1; redirect = 1'b1; redirect_addr = 10'd50;
        step();
        chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_pc", 32'(pc), 1);
        chk("t6_count", 32'(instr_count), 0);
        chk("t6_halted", 32'(halted), 0);
        rst_n = 1'b1; start = 1'b0;
        step();
        chk("t6_idle_redir_pc", 32'(pc), 1);
        chk("t6_idle_valid", 32'(instr_valid), 0);
        redirect = 1'b0;
        step();
        chk("t6_idle_pc", 32'(pc), 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
